// File: rtl/fpc_tag_ctrl_pkg.sv
// ============================================================================
// Module  : fpc_tag_ctrl_pkg
// Brief   : Shared constants, completion-tag layout and helpers for the
//           FPC read-tag scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpc_tag_ctrl_pkg;

    localparam int NUM_CH      = 4;
    localparam int TAG_W       = 8;
    localparam int TAG_CH_LSB  = 4;
    localparam int TAG_LOW_MSB = 2;

    // Completion tag layout: {2'b0, ch[1:0], 1'b0, low[2:0]}
    typedef struct packed {
        logic [1:0]           ch;
        logic [TAG_LOW_MSB:0] low;
    } cpl_fields_t;

    function automatic cpl_fields_t tag_unpack(input logic [TAG_W-1:0] tag);
        cpl_fields_t f;
        f.ch  = tag[TAG_CH_LSB +: 2];
        f.low = tag[TAG_LOW_MSB:0];
        return f;
    endfunction

    function automatic logic [TAG_W-1:0] tag_pack(input logic [1:0] ch,
                                                  input logic [TAG_LOW_MSB:0] low);
        return {2'b00, ch, 1'b0, low};
    endfunction

    function automatic logic [2:0] popcount4(input logic [NUM_CH-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpc_tag_ctrl_if.sv
// ============================================================================
// Module  : fpc_tag_ctrl_if
// Brief   : Request, completion and release signals of the FPC tag scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpc_tag_ctrl_if #(
    parameter int NBITS_TAG_LOW = 3
);
    import fpc_tag_ctrl_pkg::*;

    localparam int NBL   = NBITS_TAG_LOW;
    localparam int DEPTH = 1 << NBL;
    localparam int OUT_W = $clog2(NUM_CH * DEPTH + 1);

    logic [NUM_CH-1:0]     rr_valid;
    logic [NUM_CH*NBL-1:0] rr_tag_low;
    logic [NUM_CH-1:0]     rr_ready;
    logic                  cpl_valid;
    logic [TAG_W-1:0]      cpl_tag;
    logic                  cpl_last;
    logic [NUM_CH-1:0]     done_valid;
    logic [NUM_CH*NBL-1:0] done_tag_low;
    logic [NUM_CH-1:0]     done_ack;
    logic [NUM_CH-1:0]     chan_flush;
    logic [NUM_CH-1:0]     idle;
    logic [OUT_W-1:0]      outstanding;
    logic                  cpl_err;

    modport master (
        output rr_ready, cpl_valid, cpl_tag, cpl_last, done_ack, chan_flush,
        input  rr_valid, rr_tag_low, done_valid, done_tag_low, idle,
               outstanding, cpl_err
    );

    modport slave (
        input  rr_ready, cpl_valid, cpl_tag, cpl_last, done_ack, chan_flush,
        output rr_valid, rr_tag_low, done_valid, done_tag_low, idle,
               outstanding, cpl_err
    );

endinterface

`default_nettype wire

// File: rtl/fpc_tag_ctrl_ring.sv
// ============================================================================
// Module  : fpc_tag_ring
// Brief   : One channel's tag ring: issue, completion marking, in-order
//           release and flush draining.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpc_tag_ring #(
    parameter int NBITS_TAG_LOW = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     issue_allow,
    input  logic                     rr_ready,
    output logic                     rr_valid,
    output logic [NBITS_TAG_LOW-1:0] rr_tag_low,
    output logic                     issue,
    input  logic                     cpl_en,
    input  logic [NBITS_TAG_LOW-1:0] cpl_low,
    output logic                     cpl_hit,
    input  logic                     done_ack,
    output logic                     done_valid,
    output logic [NBITS_TAG_LOW-1:0] done_tag_low,
    output logic                     idle
);

    localparam int NBL   = NBITS_TAG_LOW;
    localparam int DEPTH = 1 << NBL;
    localparam logic [NBL:0] PTR_ONE = (NBL+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [NBL:0]       wptr;
    logic [NBL:0]       rptr;
    logic [DEPTH-1:0]   inflight;
    logic [DEPTH-1:0]   done;
    logic [NBL-1:0]     wslot;
    logic [NBL-1:0]     rslot;
    logic               full;
    logic               empty;
    logic               head_done;
    logic               pop_head;

    assign wslot = wptr[NBL-1:0];
    assign rslot = rptr[NBL-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[NBL] != rptr[NBL]) && (wslot == rslot);

    assign rr_valid     = ~reset & ~full & ~flush & issue_allow;
    assign rr_tag_low   = wslot;
    assign issue        = rr_valid & rr_ready;
    assign cpl_hit      = cpl_en & inflight[cpl_low];
    assign head_done    = ~empty & done[rslot];
    assign done_valid   = head_done & ~flush;
    assign done_tag_low = rslot;
    assign idle         = empty;
    // While flushing, completed head entries drain one per cycle without an ack
    assign pop_head     = head_done & (flush | done_ack);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= '0;
            done     <= '0;
        end else begin
            if (issue) begin
                wptr            <= wptr + PTR_ONE;
                inflight[wslot] <= 1'b1;
                done[wslot]     <= 1'b0;
            end
            if (cpl_hit) begin
                inflight[cpl_low] <= 1'b0;
                done[cpl_low]     <= 1'b1;
            end
            if (pop_head) begin
                rptr        <= rptr + PTR_ONE;
                done[rslot] <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpc_tag_ctrl.sv
// ============================================================================
// Module  : fpc_tag_ctrl
// Brief   : Read-tag scheduler for four FPC read channels with a global
//           in-flight limit and in-order tag release.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpc_tag_ctrl
    import fpc_tag_ctrl_pkg::*;
#(
    parameter logic [NUM_CH-1:0] ENABLE          = 4'b0011,
    parameter int                NBITS_TAG_LOW   = 3,
    parameter int                MAX_OUTSTANDING = 16
) (
    input  logic          clock,
    input  logic          reset,
    fpc_tag_ctrl_if.slave bus
);

    localparam int NBL   = NBITS_TAG_LOW;
    localparam int DEPTH = 1 << NBL;
    localparam int OUT_W = $clog2(NUM_CH * DEPTH + 1);
    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

    logic [OUT_W-1:0]      outstanding;
    logic                  cpl_err;
    logic                  issue_allow;
    logic                  cpl_evt;
    cpl_fields_t           cpl_f;
    logic [NUM_CH-1:0]     issue;
    logic [NUM_CH-1:0]     cpl_hit;
    logic [NUM_CH-1:0]     rr_valid;
    logic [NUM_CH-1:0]     done_valid;
    logic [NUM_CH-1:0]     idle;
    logic [NUM_CH*NBL-1:0] rr_tag_low;
    logic [NUM_CH*NBL-1:0] done_tag_low;
    logic                  unused_ok;

    assign cpl_f       = tag_unpack(bus.cpl_tag);
    assign cpl_evt     = bus.cpl_valid & bus.cpl_last;
    assign issue_allow = (outstanding < MAX_CNT);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            if (ENABLE[i]) begin : g_ring
                fpc_tag_ring #(
                    .NBITS_TAG_LOW(NBL)
                ) u_ring (
                    .clock        (clock),
                    .reset        (reset),
                    .flush        (bus.chan_flush[i]),
                    .issue_allow  (issue_allow),
                    .rr_ready     (bus.rr_ready[i]),
                    .rr_valid     (rr_valid[i]),
                    .rr_tag_low   (rr_tag_low[i*NBL +: NBL]),
                    .issue        (issue[i]),
                    .cpl_en       (cpl_evt && (cpl_f.ch == 2'(i))),
                    .cpl_low      (cpl_f.low[NBL-1:0]),
                    .cpl_hit      (cpl_hit[i]),
                    .done_ack     (bus.done_ack[i]),
                    .done_valid   (done_valid[i]),
                    .done_tag_low (done_tag_low[i*NBL +: NBL]),
                    .idle         (idle[i])
                );
            end else begin : g_off
                assign rr_valid[i]                = 1'b0;
                assign rr_tag_low[i*NBL +: NBL]   = '0;
                assign issue[i]                   = 1'b0;
                assign cpl_hit[i]                 = 1'b0;
                assign done_valid[i]              = 1'b0;
                assign done_tag_low[i*NBL +: NBL] = '0;
                assign idle[i]                    = 1'b1;
            end
        end
    endgenerate

    // At most one channel can match a completion, so the decrement is 0 or 1
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
            cpl_err     <= 1'b0;
        end else begin
            outstanding <= outstanding + OUT_W'(popcount4(issue)) - OUT_W'(|cpl_hit);
            cpl_err     <= cpl_evt & ~(|cpl_hit);
        end
    end

    assign bus.rr_valid     = rr_valid;
    assign bus.rr_tag_low   = rr_tag_low;
    assign bus.done_valid   = done_valid;
    assign bus.done_tag_low = done_tag_low;
    assign bus.idle         = idle;
    assign bus.outstanding  = outstanding;
    assign bus.cpl_err      = cpl_err;

    assign unused_ok = ^{cpl_f, bus.rr_ready, bus.done_ack, bus.chan_flush};

endmodule

`default_nettype wire

// File: tb/tb_fpc_tag_ctrl.sv
// ============================================================================
// Module  : tb_fpc_tag_ctrl
// Brief   : Self-checking bench: vector table, corner sequences and a
//           queue-based reference model under random traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpc_tag_ctrl;
    import fpc_tag_ctrl_pkg::*;

    localparam logic [3:0] ENA = 4'b0011;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    fpc_tag_ctrl_if #(.NBITS_TAG_LOW(3)) ifa ();
    fpc_tag_ctrl_if #(.NBITS_TAG_LOW(3)) ifb ();

    fpc_tag_ctrl #(.ENABLE(ENA), .NBITS_TAG_LOW(3), .MAX_OUTSTANDING(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
    );

    fpc_tag_ctrl #(.ENABLE(ENA), .NBITS_TAG_LOW(3), .MAX_OUTSTANDING(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
    );

    typedef struct {
        logic [3:0] rdy;
        logic       cv;
        logic [7:0] ctag;
        logic       cl;
        logic [3:0] ack;
        logic [3:0] rv;
        logic [2:0] tag0;
        logic [3:0] dv;
        logic [2:0] dtag0;
        logic [5:0] outs;
        logic       err;
        logic [3:0] idle;
    } vec_t;

    typedef struct packed {
        logic [2:0] tag;
        logic       done;
    } ent_t;

    vec_t       tbl [25];
    ent_t       mq [4][$];
    int         mnext [4];
    int         mout;
    logic       merr;
    logic [7:0] cand [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.rr_ready = '0; ifa.cpl_valid = 1'b0; ifa.cpl_tag = '0; ifa.cpl_last = 1'b0;
        ifa.done_ack = '0; ifa.chan_flush = '0;
        ifb.rr_ready = '0; ifb.cpl_valid = 1'b0; ifb.cpl_tag = '0; ifb.cpl_last = 1'b0;
        ifb.done_ack = '0; ifb.chan_flush = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(logic [3:0] rdy, logic cv, logic [7:0] ctag, logic cl,
                                logic [3:0] ack, logic [3:0] rv, logic [2:0] tag0,
                                logic [3:0] dv, logic [2:0] dtag0, logic [5:0] outs,
                                logic err, logic [3:0] idle);
        vec_t v;
        v.rdy = rdy; v.cv = cv; v.ctag = ctag; v.cl = cl; v.ack = ack;
        v.rv = rv; v.tag0 = tag0; v.dv = dv; v.dtag0 = dtag0;
        v.outs = outs; v.err = err; v.idle = idle;
        return v;
    endfunction

    task automatic apply_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            ifa.rr_ready  = tbl[r].rdy;
            ifa.cpl_valid = tbl[r].cv;
            ifa.cpl_tag   = tbl[r].ctag;
            ifa.cpl_last  = tbl[r].cl;
            ifa.done_ack  = tbl[r].ack;
            @(negedge clock);
            check($sformatf("tbl%0d_rr_valid", r),    ifa.rr_valid,          tbl[r].rv);
            check($sformatf("tbl%0d_rr_tag0", r),     ifa.rr_tag_low[2:0],   tbl[r].tag0);
            check($sformatf("tbl%0d_done_valid", r),  ifa.done_valid,        tbl[r].dv);
            check($sformatf("tbl%0d_done_tag0", r),   ifa.done_tag_low[2:0], tbl[r].dtag0);
            check($sformatf("tbl%0d_outstanding", r), ifa.outstanding,       tbl[r].outs);
            check($sformatf("tbl%0d_cpl_err", r),     ifa.cpl_err,           tbl[r].err);
            check($sformatf("tbl%0d_idle", r),        ifa.idle,              tbl[r].idle);
            tick();
        end
        clear_inputs();
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            mnext[c] = 0;
        end
        mout = 0;
        merr = 1'b0;
    endtask

    // Predicts outputs from the queue view, compares, then advances the model
    task automatic model_cycle();
        logic [3:0]  erv, edv, eidle;
        logic [11:0] etag, edtag;
        logic [3:0]  pop;
        int          ch;
        logic [2:0]  t;
        bit          found;
        ent_t        e;
        for (int c = 0; c < 4; c++) begin
            erv[c]   = ENA[c] && mq[c].size() < 8 && !ifa.chan_flush[c] && mout < 16;
            edv[c]   = ENA[c] && mq[c].size() > 0 && mq[c][0].done && !ifa.chan_flush[c];
            eidle[c] = !ENA[c] || mq[c].size() == 0;
            etag[c*3 +: 3]  = ENA[c] ? 3'(mnext[c]) : 3'd0;
            edtag[c*3 +: 3] = !ENA[c] ? 3'd0 : (mq[c].size() > 0 ? mq[c][0].tag : 3'(mnext[c]));
            pop[c] = ENA[c] && mq[c].size() > 0 && mq[c][0].done &&
                     (ifa.chan_flush[c] || ifa.done_ack[c]);
        end
        @(negedge clock);
        check("rnd_rr_valid",     ifa.rr_valid,     erv);
        check("rnd_rr_tag_low",   ifa.rr_tag_low,   etag);
        check("rnd_done_valid",   ifa.done_valid,   edv);
        check("rnd_done_tag_low", ifa.done_tag_low, edtag);
        check("rnd_idle",         ifa.idle,         eidle);
        check("rnd_outstanding",  ifa.outstanding,  mout);
        check("rnd_cpl_err",      ifa.cpl_err,      merr);
        merr = 1'b0;
        if (ifa.cpl_valid && ifa.cpl_last) begin
            ch = int'(ifa.cpl_tag[5:4]);
            t  = ifa.cpl_tag[2:0];
            found = 0;
            if (ENA[ch]) begin
                for (int j = 0; j < mq[ch].size(); j++) begin
                    if (!mq[ch][j].done && mq[ch][j].tag == t) begin
                        e = mq[ch][j];
                        e.done = 1'b1;
                        mq[ch][j] = e;
                        found = 1;
                        mout--;
                        break;
                    end
                end
            end
            if (!found) merr = 1'b1;
        end
        for (int c = 0; c < 4; c++) begin
            if (pop[c]) void'(mq[c].pop_front());
            if (erv[c] && ifa.rr_ready[c]) begin
                e.tag  = 3'(mnext[c]);
                e.done = 1'b0;
                mq[c].push_back(e);
                mnext[c] = (mnext[c] + 1) % 8;
                mout++;
            end
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;

        for (int k = 0; k <= 8; k++)
            tbl[k] = mk(4'h1, 1'b0, 8'h00, 1'b0, 4'h0, (k < 8) ? 4'h3 : 4'h2, 3'(k),
                        4'h0, 3'd0, 6'(k), 1'b0, (k == 0) ? 4'hF : 4'hE);
        tbl[9]  = mk(4'h1, 0, 8'h00, 0, 4'h0, 4'h3, 3'd0, 4'h0, 3'd0, 6'd0, 0, 4'hF);
        tbl[10] = mk(4'h1, 0, 8'h00, 0, 4'h0, 4'h3, 3'd1, 4'h0, 3'd0, 6'd1, 0, 4'hE);
        tbl[11] = mk(4'h1, 0, 8'h00, 0, 4'h0, 4'h3, 3'd2, 4'h0, 3'd0, 6'd2, 0, 4'hE);
        tbl[12] = mk(4'h0, 1, 8'h00, 0, 4'h0, 4'h3, 3'd3, 4'h0, 3'd0, 6'd3, 0, 4'hE);
        tbl[13] = mk(4'h0, 1, 8'h02, 1, 4'h0, 4'h3, 3'd3, 4'h0, 3'd0, 6'd3, 0, 4'hE);
        tbl[14] = mk(4'h0, 1, 8'h00, 1, 4'h0, 4'h3, 3'd3, 4'h0, 3'd0, 6'd2, 0, 4'hE);
        tbl[15] = mk(4'h0, 1, 8'h01, 1, 4'h0, 4'h3, 3'd3, 4'h1, 3'd0, 6'd1, 0, 4'hE);
        tbl[16] = mk(4'h0, 0, 8'h00, 0, 4'h1, 4'h3, 3'd3, 4'h1, 3'd0, 6'd0, 0, 4'hE);
        tbl[17] = mk(4'h0, 0, 8'h00, 0, 4'h1, 4'h3, 3'd3, 4'h1, 3'd1, 6'd0, 0, 4'hE);
        tbl[18] = mk(4'h0, 0, 8'h00, 0, 4'h1, 4'h3, 3'd3, 4'h1, 3'd2, 6'd0, 0, 4'hE);
        tbl[19] = mk(4'h0, 0, 8'h00, 0, 4'h0, 4'h3, 3'd3, 4'h0, 3'd3, 6'd0, 0, 4'hF);
        tbl[20] = mk(4'h0, 1, 8'h13, 1, 4'h0, 4'h3, 3'd3, 4'h0, 3'd3, 6'd0, 0, 4'hF);
        tbl[21] = mk(4'h0, 1, 8'h00, 1, 4'h0, 4'h3, 3'd3, 4'h0, 3'd3, 6'd0, 1, 4'hF);
        tbl[22] = mk(4'h0, 0, 8'h00, 0, 4'h0, 4'h3, 3'd3, 4'h0, 3'd3, 6'd0, 1, 4'hF);
        tbl[23] = mk(4'h0, 0, 8'h00, 0, 4'h0, 4'h3, 3'd3, 4'h0, 3'd3, 6'd0, 0, 4'hF);
        tbl[24] = mk(4'h0, 0, 8'h00, 0, 4'h0, 4'h3, 3'd3, 4'h0, 3'd3, 6'd0, 0, 4'hF);

        // Fill ch0 to full, then out-of-order completion and bad completions
        do_reset();
        apply_rows(0, 8);
        do_reset();
        apply_rows(9, 24);

        // Flush with outstanding tags completing out of order
        do_reset();
        ifa.rr_ready = 4'h1;
        repeat (4) tick();
        ifa.rr_ready   = 4'h0;
        ifa.chan_flush = 4'h1;
        ifa.cpl_valid  = 1'b1;
        ifa.cpl_last   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ifa.cpl_tag = tag_pack(2'd0, (k == 0) ? 3'd1 : (k == 1) ? 3'd3 : (k == 2) ? 3'd0 : 3'd2);
            @(negedge clock);
            check("flush_rr_valid0", ifa.rr_valid[0], 1'b0);
            check("flush_done_valid0", ifa.done_valid[0], 1'b0);
            if (k == 3) check("flush_not_idle", ifa.idle[0], 1'b0);
            tick();
        end
        ifa.cpl_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check("flush_drain_dv0", ifa.done_valid[0], 1'b0);
            if (ifa.idle[0]) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("flush_idle_reached", seen, 1'b1);
        check("flush_outstanding", ifa.outstanding, 6'd0);
        check("flush_wptr", ifa.rr_tag_low[2:0], 3'd4);
        check("flush_rptr", ifa.done_tag_low[2:0], 3'd4);
        tick();
        ifa.chan_flush = 4'h0;
        @(negedge clock);
        check("post_flush_rr_valid0", ifa.rr_valid[0], 1'b1);
        check("post_flush_tag0", ifa.rr_tag_low[2:0], 3'd4);

        // Reset in the middle of traffic
        tick();
        ifa.rr_ready = 4'h1;
        repeat (2) tick();
        ifa.rr_ready = 4'h0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_rr_valid", ifa.rr_valid, 4'h0);
        check("rst_done_valid", ifa.done_valid, 4'h0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_outstanding", ifa.outstanding, 6'd0);
        check("rst_idle", ifa.idle, 4'hF);
        check("rst_tag0", ifa.rr_tag_low[2:0], 3'd0);
        check("rst_rr_valid_after", ifa.rr_valid, 4'h3);
        ifa.cpl_valid = 1'b1;
        ifa.cpl_last  = 1'b1;
        ifa.cpl_tag   = tag_pack(2'd0, 3'd4);
        tick();
        ifa.cpl_valid = 1'b0;
        @(negedge clock);
        check("rst_stale_cpl_err", ifa.cpl_err, 1'b1);
        check("rst_stale_outstanding", ifa.outstanding, 6'd0);
        tick();

        // Global limit of 4 on the second instance
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ifb.rr_ready = (k % 2 == 0) ? 4'h1 : 4'h2;
            @(negedge clock);
            check("max_rr_valid_open", ifb.rr_valid, 4'h3);
            tick();
        end
        ifb.rr_ready = 4'h3;
        @(negedge clock);
        check("max_rr_valid_closed", ifb.rr_valid, 4'h0);
        check("max_outstanding", ifb.outstanding, 4'd4);
        tick();
        ifb.cpl_valid = 1'b1;
        ifb.cpl_last  = 1'b1;
        ifb.cpl_tag   = tag_pack(2'd0, 3'd0);
        @(negedge clock);
        check("max_still_closed", ifb.rr_valid, 4'h0);
        tick();
        ifb.cpl_valid = 1'b0;
        ifb.rr_ready  = 4'h0;
        @(negedge clock);
        check("max_reopen_outstanding", ifb.outstanding, 4'd3);
        check("max_reopen_rr_valid", ifb.rr_valid, 4'h3);
        tick();

        // Random traffic against the queue model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ifa.rr_ready = 4'($urandom);
            ifa.done_ack = 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                if (ifa.chan_flush[c]) begin
                    if (mq[c].size() == 0 && $urandom_range(0, 1) == 1) ifa.chan_flush[c] = 1'b0;
                end else if ($urandom_range(0, 63) == 0) begin
                    ifa.chan_flush[c] = 1'b1;
                end
            end
            cand.delete();
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < mq[c].size(); j++)
                    if (!mq[c][j].done) cand.push_back(tag_pack(2'(c), mq[c][j].tag));
            ifa.cpl_valid = ($urandom_range(0, 9) < 6);
            ifa.cpl_last  = ($urandom_range(0, 9) < 8);
            if (cand.size() > 0 && $urandom_range(0, 4) != 0)
                ifa.cpl_tag = cand[$urandom_range(0, cand.size() - 1)];
            else
                ifa.cpl_tag = 8'($urandom);
            model_cycle();
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
